byte_ser_feed: RTL and testbench

BYTE_SER_FEED -- requirements
Module: byte_ser_feed

---
 rtl/byte_ser_feed.sv | 189 ++++++++++++++++++
 tb/tb_byte_ser_feed.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_ser_feed.sv
// byte_ser_feed: byte-to-bit serializer feeding a downstream CRC5 stage.
// Accepts bytes with a valid/ready handshake. Each frame is announced with a
// frame_start pulse, its bits stream out on ser_data/ser_en (MSB first by
// default), a frame_done pulse follows the last bit, and GAP_CYCLES idle cycles
// are then forced before the next frame can be accepted.
// Optional build macro: BYTE_SER_FEED_LSB_FIRST_EN -> emit bits LSB first.
// Reset is asynchronous, active-high.
module byte_ser_feed #(
    parameter int GAP_CYCLES = 1    // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       ser_data,
    output logic       ser_en,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // Final value of the gap counter before returning to IDLE.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       last_reg, last_next;

    logic       ser_data_reg, ser_data_next;
    logic       ser_en_reg, ser_en_next;
    logic       frame_start_reg, frame_start_next;
    logic       frame_done_reg, frame_done_next;
    logic       busy_reg, busy_next;

    logic       accept;
    logic [7:0] tx_order;   // tx_order[k] is the k-th bit to leave the block

    // Ready depends only on registered state: idle, waiting mid-frame, or on
    // the final bit of a byte that is not the end of the frame.
    assign in_ready = (state_reg == ST_IDLE) ||
                      (state_reg == ST_WAIT) ||
                      ((state_reg == ST_SHIFT) && (bit_cnt_reg == 3'd7) && !last_reg);

    assign accept = in_valid && in_ready;

    // Map the held byte to transmit order, selected by the bit-order macro.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_order
`ifdef BYTE_SER_FEED_LSB_FIRST_EN
            assign tx_order[gi] = shift_next[gi];
`else
            assign tx_order[gi] = shift_next[7 - gi];
`endif
        end
    endgenerate

    // State register: FSM state, counters, held byte and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= 3'd0;
            gap_cnt_reg     <= 4'd0;
            shift_reg       <= 8'd0;
            last_reg        <= 1'b0;
            ser_data_reg    <= 1'b0;
            ser_en_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            shift_reg       <= shift_next;
            last_reg        <= last_next;
            ser_data_reg    <= ser_data_next;
            ser_en_reg      <= ser_en_next;
            frame_start_reg <= frame_start_next;
            frame_done_reg  <= frame_done_next;
            busy_reg        <= busy_next;
        end
    end

    // Next-state logic: frame sequencing, byte capture and counters.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        shift_next   = shift_reg;
        last_next    = last_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_START;
                    shift_next   = in_data;
                    last_next    = in_last;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_START: begin
                state_next   = ST_SHIFT;
                bit_cnt_next = 3'd0;
            end
            ST_SHIFT: begin
                if (bit_cnt_reg == 3'd7) begin
                    if (last_reg) begin
                        state_next = ST_DONE;
                    end else if (accept) begin
                        // Next byte continues the frame with no bubble.
                        state_next   = ST_SHIFT;
                        shift_next   = in_data;
                        last_next    = in_last;
                        bit_cnt_next = 3'd0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                end
            end
            ST_WAIT: begin
                // Frame stays open until upstream supplies the next byte.
                if (accept) begin
                    state_next   = ST_SHIFT;
                    shift_next   = in_data;
                    last_next    = in_last;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DONE: begin
                state_next   = ST_GAP;
                gap_cnt_next = 4'd0;
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next   = ST_IDLE;
                    gap_cnt_next = 4'd0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = 3'd0;
                gap_cnt_next = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        ser_data_next    = 1'b0;
        ser_en_next      = 1'b0;
        frame_start_next = 1'b0;
        frame_done_next  = 1'b0;
        busy_next        = (state_next != ST_IDLE);

        case (state_next)
            ST_START: frame_start_next = 1'b1;
            ST_SHIFT: begin
                ser_en_next   = 1'b1;
                ser_data_next = tx_order[bit_cnt_next];
            end
            ST_DONE:  frame_done_next = 1'b1;
            default:  ;
        endcase
    end

    assign ser_data    = ser_data_reg;
    assign ser_en      = ser_en_reg;
    assign frame_start = frame_start_reg;
    assign frame_done  = frame_done_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_byte_ser_feed.sv
// tb_byte_ser_feed: self-checking bench for byte_ser_feed (GAP_CYCLES = 3).
// Table of single-byte frames with cycle-exact checks, hand-written multi-byte
// and reset sequences, then randomized frames scored against a bit-order model.
module tb_byte_ser_feed;

    localparam int GAP = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic       ser_data;
    logic       ser_en;
    logic       frame_start;
    logic       frame_done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    byte_ser_feed #(.GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .ser_data    (ser_data),
        .ser_en      (ser_en),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    int   cyc             = 0;
    bit   mon_bits[$];
    int   mon_starts      = 0;
    int   mon_dones       = 0;
    int   mon_runs        = 0;
    int   mon_zero_err    = 0;
    int   mon_last_en_cyc = 0;
    int   mon_start_gap[$];
    logic prev_en         = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ser_en === 1'b1) begin
            mon_bits.push_back(ser_data);
            if (prev_en !== 1'b1) mon_runs = mon_runs + 1;
            mon_last_en_cyc = cyc;
        end else if (ser_data !== 1'b0) begin
            mon_zero_err = mon_zero_err + 1;
        end
        if (frame_start === 1'b1) begin
            mon_starts = mon_starts + 1;
            mon_start_gap.push_back(cyc - mon_last_en_cyc);
        end
        if (frame_done === 1'b1) mon_dones = mon_dones + 1;
        prev_en = ser_en;
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_seq;    // bit 7 = first bit expected on ser_data
    } vec_t;

    vec_t vecs[6];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting on DUT, got no response, expected handshake", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit order the serial line must follow for one byte (bit 7 = first out).
    function automatic logic [7:0] ser_order(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
`ifdef BYTE_SER_FEED_LSB_FIRST_EN
            r[7 - i] = b[i];
`else
            r[7 - i] = b[7 - i];
`endif
        end
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            step();
            k++;
        end
        if (busy !== 1'b0) timeout_fail(name);
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (in_ready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        if (in_ready !== 1'b1) timeout_fail(name);
    endtask

    // Present a byte after `delay` idle cycles; junk is driven while not ready.
    // Returns just after the accepting edge with in_valid dropped.
    task automatic send_byte(input logic [7:0] data, input logic last, input int delay);
        int k = 0;
        in_valid = 1'b0;
        repeat (delay) step();
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && k < 200) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            step();
            k++;
        end
        if (in_ready !== 1'b1) timeout_fail("send_byte");
        in_data = data;
        in_last = last;
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Single-byte frame with cycle-exact checks from accept through the gap.
    task automatic run_single(input logic [7:0] data, input logic last, input logic [7:0] exp_seq);
        string tag;
        tag = $sformatf("byte_%02h", data);
        wait_idle({tag, "_idle"});
        check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
        send_byte(data, last, 0);
        check_bit({tag, "_start_pulse"}, frame_start, 1'b1);
        check_bit({tag, "_start_ser_en"}, ser_en, 1'b0);
        check_bit({tag, "_start_ready"}, in_ready, 1'b0);
        check_bit({tag, "_start_busy"}, busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            check_bit($sformatf("%s_shift_en_%0d", tag, i), ser_en, 1'b1);
            check_bit($sformatf("%s_shift_bit_%0d", tag, i), ser_data, exp_seq[7 - i]);
            check_bit($sformatf("%s_shift_ready_%0d", tag, i), in_ready, 1'b0);
            check_bit($sformatf("%s_shift_nostart_%0d", tag, i), frame_start, 1'b0);
        end
        step();
        check_bit({tag, "_done_pulse"}, frame_done, 1'b1);
        check_bit({tag, "_done_ser_en"}, ser_en, 1'b0);
        check_bit({tag, "_done_ser_data"}, ser_data, 1'b0);
        check_bit({tag, "_done_ready"}, in_ready, 1'b0);
        for (int g = 0; g < GAP; g++) begin
            step();
            check_bit($sformatf("%s_gap_ready_%0d", tag, g), in_ready, 1'b0);
            check_bit($sformatf("%s_gap_busy_%0d", tag, g), busy, 1'b1);
            check_bit($sformatf("%s_gap_nodone_%0d", tag, g), frame_done, 1'b0);
        end
        step();
        check_bit({tag, "_post_ready"}, in_ready, 1'b1);
        check_bit({tag, "_post_busy"}, busy, 1'b0);
    endtask

    // Collect serial bits captured since index `from` into a vector.
    function automatic logic [23:0] collect(input int from, input int n);
        logic [23:0] v = '0;
        for (int k = 0; k < n && (from + k) < mon_bits.size(); k++)
            v = {v[22:0], logic'(mon_bits[from + k])};
        return v;
    endfunction

    initial begin
        int m_bits, m_st, m_dn, m_runs, m_gap;
        logic [23:0] exp_vec;

        vecs[0] = '{8'hC1, 1'b1, 8'hC1};
        vecs[1] = '{8'h55, 1'b1, 8'h55};
        vecs[2] = '{8'hF0, 1'b1, 8'hF0};
        vecs[3] = '{8'h01, 1'b1, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 8'h80};
        vecs[5] = '{8'h3C, 1'b1, 8'h3C};
`ifdef BYTE_SER_FEED_LSB_FIRST_EN
        vecs[0].exp_seq = 8'h83;
        vecs[1].exp_seq = 8'hAA;
        vecs[2].exp_seq = 8'h0F;
        vecs[3].exp_seq = 8'h80;
        vecs[4].exp_seq = 8'h01;
        vecs[5].exp_seq = 8'h3C;
`endif

        // Reset state.
        step();
        step();
        check_bit("rst_ser_en", ser_en, 1'b0);
        check_bit("rst_ser_data", ser_data, 1'b0);
        check_bit("rst_frame_start", frame_start, 1'b0);
        check_bit("rst_frame_done", frame_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();
        check_bit("post_rst_ready", in_ready, 1'b1);
        check_bit("post_rst_busy", busy, 1'b0);

        // Table-driven single-byte frames.
        foreach (vecs[i]) run_single(vecs[i].data, vecs[i].last, vecs[i].exp_seq);

        // Two bytes back to back: 16 contiguous bits, one start, one done.
        wait_idle("b2b_idle");
        m_bits = mon_bits.size(); m_st = mon_starts; m_dn = mon_dones; m_runs = mon_runs;
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'h0F, 1'b1, 0);
        wait_idle("b2b_end");
        exp_vec = {8'h00, ser_order(8'hF0), ser_order(8'h0F)};
        check_int("b2b_nbits", mon_bits.size() - m_bits, 16);
        check_int("b2b_bits", int'(collect(m_bits, 16)), int'(exp_vec));
        check_int("b2b_runs", mon_runs - m_runs, 1);
        check_int("b2b_starts", mon_starts - m_st, 1);
        check_int("b2b_dones", mon_dones - m_dn, 1);

        // Second byte delayed: three WAIT cycles, frame held open.
        wait_idle("wait_idle");
        m_bits = mon_bits.size(); m_st = mon_starts; m_dn = mon_dones; m_runs = mon_runs;
        send_byte(8'hF0, 1'b0, 0);
        wait_ready("wait_bit7");
        for (int k = 0; k < 3; k++) begin
            step();
            check_bit($sformatf("wait_ser_en_%0d", k), ser_en, 1'b0);
            check_bit($sformatf("wait_busy_%0d", k), busy, 1'b1);
            check_bit($sformatf("wait_ready_%0d", k), in_ready, 1'b1);
        end
        send_byte(8'h0F, 1'b1, 0);
        wait_idle("wait_end");
        check_int("wait_nbits", mon_bits.size() - m_bits, 16);
        check_int("wait_bits", int'(collect(m_bits, 16)), int'(exp_vec));
        check_int("wait_runs", mon_runs - m_runs, 2);
        check_int("wait_starts", mon_starts - m_st, 1);
        check_int("wait_dones", mon_dones - m_dn, 1);

        // Reset in the middle of 0xAA, then a clean 0x55 frame.
        wait_idle("mrst_idle");
        send_byte(8'hAA, 1'b1, 0);
        repeat (5) step();
        check_bit("mrst_pre_ser_en", ser_en, 1'b1);
        m_dn = mon_dones;
        rst = 1'b1;
        #1;
        check_bit("mrst_ser_en", ser_en, 1'b0);
        check_bit("mrst_ser_data", ser_data, 1'b0);
        check_bit("mrst_frame_start", frame_start, 1'b0);
        check_bit("mrst_frame_done", frame_done, 1'b0);
        check_bit("mrst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        check_bit("mrst_ready", in_ready, 1'b1);
        step();
        check_bit("mrst_ready_after", in_ready, 1'b1);
        m_bits = mon_bits.size(); m_st = mon_starts;
        send_byte(8'h55, 1'b1, 0);
        wait_idle("mrst_end");
        check_int("mrst_dones", mon_dones - m_dn, 1);
        check_int("mrst_starts", mon_starts - m_st, 1);
        check_int("mrst_bits", int'(collect(m_bits, 8)), int'(ser_order(8'h55)));

        // in_valid held high across frames: DONE + GAP cycles before next accept.
        wait_idle("hold_idle");
        m_gap = mon_start_gap.size(); m_st = mon_starts;
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'hA5, 1'b1, 0);
        wait_idle("hold_end");
        check_int("hold_starts", mon_starts - m_st, 2);
        if (mon_start_gap.size() >= m_gap + 2)
            check_int("hold_start_spacing", mon_start_gap[m_gap + 1], GAP + 3);
        else
            timeout_fail("hold_start_spacing");

        // Randomized frames against the bit-order model.
        for (int f = 0; f < 30; f++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            wait_idle("rnd_idle");
            m_bits = mon_bits.size(); m_st = mon_starts; m_dn = mon_dones;
            exp_vec = '0;
            for (int b = 0; b < nb; b++) begin
                logic [7:0] d;
                d = 8'($urandom);
                exp_vec = {exp_vec[15:0], ser_order(d)};
                send_byte(d, (b == nb - 1), int'($urandom_range(0, 3)));
            end
            wait_idle("rnd_end");
            check_int($sformatf("rnd%0d_nbits", f), mon_bits.size() - m_bits, 8 * nb);
            check_int($sformatf("rnd%0d_bits", f), int'(collect(m_bits, 8 * nb)), int'(exp_vec));
            check_int($sformatf("rnd%0d_starts", f), mon_starts - m_st, 1);
            check_int($sformatf("rnd%0d_dones", f), mon_dones - m_dn, 1);
        end

        check_int("ser_data_zero_when_idle", mon_zero_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
